spi_target_mem: RTL and testbench
=================================

SPI_TARGET_MEM -- requirements
Module: spi_target_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning byte-address width of the internal memory (2^ADDR_W bytes).
REQ-002 SHALL have parameter SCK_DIV_MIN, default 8, meaning the minimum wb_clk_i periods per spi_clk period that the design supports.
REQ-003 SHALL have port wb_clk_i  input  1  system clock; the only clock.
REQ-004 SHALL have port wb_rst_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port spi_clk  input  1  SPI clock from initiator, mode 0.
REQ-006 SHALL have port spi_cs  input  1  chip select, active-low.
REQ-007 SHALL have port spi_mosi  input  1  serial data from initiator, MSB first.
REQ-008 SHALL have port spi_miso  output  1  serial data to initiator, MSB first.
REQ-009 SHALL have port busy_o  output  1  high while a transaction is selected (synchronised spi_cs low).
REQ-010 SHALL have port err_o  output  1  one-cycle pulse on an unknown command byte.

Function
REQ-011 SHALL pass spi_clk, spi_cs and spi_mosi through 2-flop synchronisers and detect spi_clk rise and fall from the synchronised value.
REQ-012 SHALL sample spi_mosi on detected spi_clk rise and update spi_miso on detected spi_clk fall.
REQ-013 SHALL implement FSM states: IDLE, CMD, ADDR, RDATA, WDATA, IGNORE.
REQ-014 SHALL move IDLE->CMD on synchronised spi_cs falling; any state->IDLE on spi_cs high, discarding any partial byte.
REQ-015 SHALL use a 3-bit bit counter per byte; in CMD, after 8 bits, decode 0x03->ADDR(read), 0x02->ADDR(write); any other value->IGNORE with err_o pulsed in the same cycle.
REQ-016 SHALL in ADDR collect 3 bytes (24 bits, MSB first) and use the low ADDR_W bits as the start address; upper bits are ignored.
REQ-017 SHALL for read, fetch mem[addr] before the spi_clk fall following the last address bit and present bit 7 on that fall; each later fall shifts the next bit.
REQ-018 SHALL for read, increment address after each byte's bit 0 and prefetch the next byte; address wraps 2^ADDR_W-1 -> 0.
REQ-019 SHALL for write, write each complete received byte to mem[addr] in the cycle after its 8th rise, then increment with the same wrap rule.
REQ-020 SHALL drive spi_miso 0 in IDLE, CMD, ADDR, WDATA and IGNORE.
REQ-021 SHALL not write memory for an incomplete byte or in IGNORE.

Reset
REQ-022 SHALL on wb_rst_i set FSM to IDLE, counters, address and shift registers to 0, spi_miso=0, busy_o=0, err_o=0, synchronisers to idle (spi_cs=1, spi_clk=0, spi_mosi=0).
REQ-023 SHALL leave memory contents unchanged by reset.
REQ-024 SHALL when reset asserts mid-transaction, abort it, and then stay in IDLE until a new spi_cs falling edge.

Configuration
REQ-025 SHALL with macro SPI_TARGET_STATUS_EN defined, decode command 0x05 to a status state that repeatedly shifts out {7'b0, err_sticky}; err_sticky sets on any err_o pulse and clears only on reset.
REQ-026 SHALL without SPI_TARGET_STATUS_EN, treat 0x05 as unknown (IGNORE, err_o pulse), with no err_sticky register.

Structure
REQ-027 SHALL place command opcodes (0x02, 0x03, 0x05) and the FSM state encoding in shared package spraid_pkg.
REQ-028 SHALL contain one sub-module, spi_target_sync, holding the 3 synchronisers plus spi_clk edge detection.

Verification
REQ-029 SHALL cover: write 0x02,0x00,0x00,0x10,0xA5,0x5A then read 0x03,0x00,0x00,0x10 + 2 dummy bytes -> MISO returns 0xA5,0x5A.
REQ-030 SHALL cover: write 0x11,0x22 at 0x0003FF (ADDR_W=10) -> mem[0x3FF]=0x11, mem[0x000]=0x22; read back from 0x3FF returns same pair.
REQ-031 SHALL cover: command 0x9F -> err_o high exactly 1 cycle, spi_miso stays 0, memory unchanged.
REQ-032 SHALL cover: spi_cs raised after 4 data bits of a write to 0x20 -> mem[0x20] unchanged, busy_o low within 3 cycles, next transaction decodes correctly.
REQ-033 SHALL cover: wb_rst_i pulsed mid-read -> spi_miso=0, busy_o=0 next cycle; a following 0x03 read returns pre-reset memory data.
REQ-034 SHALL cover, with SPI_TARGET_STATUS_EN: 0x9F then 0x05 -> status byte 0x01; without the macro, 0x05 -> err_o pulse.

Source files
------------

// File: rtl/spraid_pkg.sv
// rtl/spraid_pkg.sv - shared opcodes and FSM encoding for the SPI target memory
package spraid_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_RDATA  = 3'd3,
    ST_WDATA  = 3'd4,
    ST_IGNORE = 3'd5,
    ST_STATUS = 3'd6
  } state_t;

endpackage

// File: rtl/spi_target_sync.sv
// rtl/spi_target_sync.sv - 2-flop synchronisers for SPI pins plus spi_clk / spi_cs edge detection
module spi_target_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_spi_clk,
  input  logic i_spi_cs,
  input  logic i_spi_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_cs_fall,
  output logic o_cs_high,
  output logic o_mosi
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_cs_sync;
  logic [1:0] r_mosi_sync;
  logic       r_clk_prev;
  logic       r_cs_prev;
  logic [1:0] r_settle;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_sync  <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_mosi_sync <= 2'b00;
      r_clk_prev  <= 1'b0;
      r_cs_prev   <= 1'b1;
      r_settle    <= 2'd0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_spi_clk};
      r_cs_sync   <= {r_cs_sync[0], i_spi_cs};
      r_mosi_sync <= {r_mosi_sync[0], i_spi_mosi};
      r_clk_prev  <= r_clk_sync[1];
      r_cs_prev   <= r_cs_sync[1];
      if (r_settle != 2'd3) begin
        r_settle <= r_settle + 2'd1;
      end
    end
  end

  // The idle value loaded at reset is not a real pin sample; a select that was
  // already low across reset must not look like a fresh falling edge.
  assign o_cs_fall   = r_cs_prev & ~r_cs_sync[1] & (r_settle == 2'd3);
  assign o_cs_high   = r_cs_sync[1];
  assign o_sclk_rise = r_clk_sync[1] & ~r_clk_prev;
  assign o_sclk_fall = ~r_clk_sync[1] & r_clk_prev;
  assign o_mosi      = r_mosi_sync[1];

endmodule

// File: rtl/spi_target_mem.sv
// rtl/spi_target_mem.sv - SPI mode-0 target with byte memory; read 0x03 / write 0x02 with auto-increment
// Optional status command 0x05 enabled by macro SPI_TARGET_STATUS_EN.
module spi_target_mem
  import spraid_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int SCK_DIV_MIN = 8
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic busy_o,
  output logic err_o
);

  if (SCK_DIV_MIN < 6) begin : g_sck_div_too_small
    $error("SCK_DIV_MIN below synchroniser plus edge-detect latency");
  end

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_bit_cnt;
  logic [2:0]          r_out_cnt;
  logic [1:0]          r_byte_cnt;
  logic                r_is_write;
  logic [7:0]          r_shift_in;
  logic [7:0]          r_shift_out;
  logic [7:0]          r_rdata;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_miso;
  logic [7:0]          r_mem [0:(2**ADDR_W)-1];

  logic                w_rise;
  logic                w_fall;
  logic                w_cs_fall;
  logic                w_cs_high;
  logic                w_mosi;
  logic                w_byte_done;
  logic [7:0]          w_byte;
  logic                w_cmd_status;
  logic                w_cmd_known;
  logic                w_tx_state;
  logic [7:0]          w_tx_byte;
  logic                w_mem_we;

  spi_target_sync u_sync (
    .i_clk       (wb_clk_i),
    .i_rst       (wb_rst_i),
    .i_spi_clk   (spi_clk),
    .i_spi_cs    (spi_cs),
    .i_spi_mosi  (spi_mosi),
    .o_sclk_rise (w_rise),
    .o_sclk_fall (w_fall),
    .o_cs_fall   (w_cs_fall),
    .o_cs_high   (w_cs_high),
    .o_mosi      (w_mosi)
  );

  assign w_byte_done = w_rise & (r_bit_cnt == 3'd7);
  assign w_byte      = {r_shift_in[6:0], w_mosi};
  assign w_tx_state  = (r_state == ST_RDATA) | (r_state == ST_STATUS);
  assign w_mem_we    = (r_state == ST_WDATA) & w_byte_done & ~w_cs_high;

`ifdef SPI_TARGET_STATUS_EN
  logic r_err_sticky;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_err_sticky <= 1'b0;
    end else if (err_o) begin
      r_err_sticky <= 1'b1;
    end
  end

  assign w_cmd_status = (w_byte == CMD_STATUS);
  assign w_tx_byte    = (r_state == ST_STATUS) ? {7'b0, r_err_sticky} : r_rdata;
`else
  assign w_cmd_status = 1'b0;
  assign w_tx_byte    = r_rdata;
`endif

  assign w_cmd_known = (w_byte == CMD_READ) | (w_byte == CMD_WRITE) | w_cmd_status;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_cs_high) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_cs_fall) w_next = ST_CMD;
        ST_CMD: begin
          if (w_byte_done) begin
            if (!w_cmd_known)     w_next = ST_IGNORE;
            else if (w_cmd_status) w_next = ST_STATUS;
            else                   w_next = ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_byte_done && r_byte_cnt == 2'd2) begin
            w_next = r_is_write ? ST_WDATA : ST_RDATA;
          end
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    busy_o   = (r_state != ST_IDLE);
    err_o    = (r_state == ST_CMD) & w_byte_done & ~w_cmd_known & ~w_cs_high;
    spi_miso = r_miso & w_tx_state;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_bit_cnt   <= 3'd0;
      r_out_cnt   <= 3'd0;
      r_byte_cnt  <= 2'd0;
      r_is_write  <= 1'b0;
      r_shift_in  <= 8'h00;
      r_shift_out <= 8'h00;
      r_addr      <= '0;
      r_miso      <= 1'b0;
    end else if (r_state == ST_IDLE || w_cs_high) begin
      r_bit_cnt  <= 3'd0;
      r_out_cnt  <= 3'd0;
      r_byte_cnt <= 2'd0;
      r_shift_in <= 8'h00;
      r_miso     <= 1'b0;
    end else begin
      if (w_rise) begin
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_shift_in <= w_byte;
      end
      if (r_state == ST_CMD && w_byte_done) begin
        r_is_write <= (w_byte == CMD_WRITE);
      end
      if (r_state == ST_ADDR && w_rise) begin
        r_addr <= {r_addr[ADDR_W-2:0], w_mosi};
      end
      if (r_state == ST_ADDR && w_byte_done) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (w_mem_we) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      // The first fall of each byte loads the prefetched byte; the eighth fall
      // has put bit 0 out, so the address can advance and prefetch the next one.
      if (w_tx_state && w_fall) begin
        if (r_out_cnt == 3'd0) begin
          r_miso      <= w_tx_byte[7];
          r_shift_out <= {w_tx_byte[6:0], 1'b0};
        end else begin
          r_miso      <= r_shift_out[7];
          r_shift_out <= {r_shift_out[6:0], 1'b0};
        end
        r_out_cnt <= r_out_cnt + 3'd1;
        if (r_state == ST_RDATA && r_out_cnt == 3'd7) begin
          r_addr <= r_addr + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && w_mem_we) begin
      r_mem[r_addr] <= w_byte;
    end
    r_rdata <= r_mem[r_addr];
  end

endmodule

// File: tb/tb_spi_target_mem.sv
// tb/tb_spi_target_mem.sv - directed bench for spi_target_mem (ADDR_W=10, spi_clk = 16 system clocks)
module tb_spi_target_mem;

  localparam int HALF = 8;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic sclk     = 1'b0;
  logic cs       = 1'b1;
  logic mosi     = 1'b0;
  logic miso;
  logic busy;
  logic err;

  int n_tests  = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int miso_cnt = 0;

  always #5 clk = ~clk;

  spi_target_mem #(.ADDR_W(10), .SCK_DIV_MIN(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .spi_clk  (sclk),
    .spi_cs   (cs),
    .spi_mosi (mosi),
    .spi_miso (miso),
    .busy_o   (busy),
    .err_o    (err)
  );

  always @(negedge clk) begin
    if (err)  err_cnt  <= err_cnt + 1;
    if (miso) miso_cnt <= miso_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic half_wait;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      half_wait();
      sclk  = 1'b1;
      rx[i] = miso;
      half_wait();
      sclk  = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_begin;
    cs = 1'b0;
    half_wait();
  endtask

  task automatic cs_end;
    half_wait();
    cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic cmd_addr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] d;
    spi_byte(cmd, d);
    spi_byte(addr[23:16], d);
    spi_byte(addr[15:8], d);
    spi_byte(addr[7:0], d);
  endtask

  task automatic write2(input logic [23:0] addr, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] d;
    cs_begin();
    cmd_addr(8'h02, addr);
    spi_byte(b0, d);
    spi_byte(b1, d);
    cs_end();
  endtask

  task automatic read2(input logic [23:0] addr, output logic [7:0] r0, output logic [7:0] r1);
    cs_begin();
    cmd_addr(8'h03, addr);
    spi_byte(8'h00, r0);
    spi_byte(8'h00, r1);
    cs_end();
  endtask

  initial begin
    logic [7:0] r0;
    logic [7:0] r1;
    int         e0;
    int         m0;

    repeat (4) @(negedge clk);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err",  {31'd0, err},  32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // basic write then read back
    cs_begin();
    spi_byte(8'h02, r0);
    check("busy_in_txn", {31'd0, busy}, 32'd1);
    spi_byte(8'h00, r0);
    spi_byte(8'h00, r0);
    spi_byte(8'h10, r0);
    spi_byte(8'hA5, r0);
    spi_byte(8'h5A, r0);
    cs_end();
    check("busy_after_txn", {31'd0, busy}, 32'd0);
    check("mem_10", {24'd0, dut.r_mem[10'h010]}, 32'hA5);
    check("mem_11", {24'd0, dut.r_mem[10'h011]}, 32'h5A);
    read2(24'h000010, r0, r1);
    check("rd_10", {24'd0, r0}, 32'hA5);
    check("rd_11", {24'd0, r1}, 32'h5A);

    // upper address bits beyond ADDR_W are ignored: 0xFFFC10 -> 0x010
    read2(24'hFFFC10, r0, r1);
    check("rd_hi_bits_ignored", {24'd0, r0}, 32'hA5);

    // write and read across the top-of-memory wrap
    write2(24'h0003FF, 8'h11, 8'h22);
    check("mem_3ff", {24'd0, dut.r_mem[10'h3FF]}, 32'h11);
    check("mem_000", {24'd0, dut.r_mem[10'h000]}, 32'h22);
    read2(24'h0003FF, r0, r1);
    check("rd_3ff", {24'd0, r0}, 32'h11);
    check("rd_wrap_000", {24'd0, r1}, 32'h22);

    // unknown command: one-cycle err pulse, MISO silent, no memory write
    e0 = err_cnt;
    m0 = miso_cnt;
    cs_begin();
    spi_byte(8'h9F, r0);
    cmd_addr(8'h00, 24'h001077);
    spi_byte(8'h00, r1);
    cs_end();
    check("err_pulse_width", err_cnt - e0, 32'd1);
    check("ignore_miso_quiet", miso_cnt - m0, 32'd0);
    check("ignore_rx", {24'd0, r1}, 32'h00);
    check("ignore_mem_10", {24'd0, dut.r_mem[10'h010]}, 32'hA5);

    // partial byte aborted by deselect
    write2(24'h000020, 8'h3C, 8'hC3);
    cs_begin();
    cmd_addr(8'h02, 24'h000020);
    spi_bits(8'hFF, 4, r0);
    cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_low", {31'd0, busy}, 32'd0);
    repeat (2 * HALF) @(negedge clk);
    check("abort_mem_20", {24'd0, dut.r_mem[10'h020]}, 32'h3C);
    read2(24'h000020, r0, r1);
    check("abort_next_rd0", {24'd0, r0}, 32'h3C);
    check("abort_next_rd1", {24'd0, r1}, 32'hC3);

    // reset pulse in the middle of a read
    cs_begin();
    cmd_addr(8'h03, 24'h000010);
    half_wait();
    check("rd_bit7_before_rst", {31'd0, miso}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_miso", {31'd0, miso}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    e0 = err_cnt;
    spi_byte(8'h9F, r0);
    check("post_rst_stays_idle", {31'd0, busy}, 32'd0);
    check("post_rst_no_err", err_cnt - e0, 32'd0);
    cs_end();
    read2(24'h000010, r0, r1);
    check("post_rst_rd0", {24'd0, r0}, 32'hA5);
    check("post_rst_rd1", {24'd0, r1}, 32'h5A);

`ifdef SPI_TARGET_STATUS_EN
    cs_begin();
    spi_byte(8'h9F, r0);
    cs_end();
    cs_begin();
    spi_byte(8'h05, r0);
    spi_byte(8'h00, r0);
    spi_byte(8'h00, r1);
    cs_end();
    check("status_byte0", {24'd0, r0}, 32'h01);
    check("status_byte1", {24'd0, r1}, 32'h01);
`else
    e0 = err_cnt;
    cs_begin();
    spi_byte(8'h05, r0);
    spi_byte(8'h00, r1);
    cs_end();
    check("cmd05_err_pulse", err_cnt - e0, 32'd1);
    check("cmd05_miso_zero", {24'd0, r1}, 32'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
